lutram_readback_checker: RTL and testbench

//  Reader/checker for a single-port distributed-RAM (LUTRAM) under test; the read side of the write-only LUTRAM test harness.
//  On start, walks every address, compares the asynchronous RAM output against the expected INIT image, then writes the

---
 rtl/lutram_chk_pkg.sv | 19 +
 rtl/lutram_chk_walker.sv | 56 +++++
 rtl/lutram_readback_checker.sv | 125 ++++++++++++
 tb/tb_lutram_readback_checker.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/lutram_chk_pkg.sv
// Shared types for the LUTRAM readback checker: run-level states and write sub-steps.
package lutram_chk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    WRITE,
    VERIFY,
    RESTORE,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    SETUP,
    STROBE,
    HOLD
  } wstep_e;

endpackage

// File: rtl/lutram_chk_walker.sv
// Address counter and per-address step timer. Read phases last SETTLE+1 steps per address,
// write phases last SETUP/STROBE/HOLD; the write enable is registered and high only in STROBE.
module lutram_chk_walker
  import lutram_chk_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              run,
  input  logic              write_mode,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] addr_next,
  output logic              sample,
  output logic              last_step,
  output logic              phase_last,
  output logic              we
);

  localparam int STEP_MAX = (SETTLE > int'(HOLD)) ? SETTLE : int'(HOLD);
  localparam int STEP_W   = $clog2(STEP_MAX + 1);

  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] limit;

  assign limit      = write_mode ? STEP_W'(int'(HOLD)) : STEP_W'(SETTLE);
  assign last_step  = (step == limit);
  assign phase_last = last_step && (addr == '1);
  assign sample     = run && !write_mode && last_step;
  assign addr_next  = addr + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      step <= '0;
      we   <= 1'b0;
    end else begin
      // SETUP is always followed by STROBE within the same address, so we is a pure lookahead.
      we <= run && write_mode && !clear && (step == STEP_W'(int'(SETUP)));
      if (clear) begin
        addr <= '0;
        step <= '0;
      end else if (run) begin
        if (last_step) begin
          step <= '0;
          addr <= addr_next;
        end else begin
          step <= step + STEP_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/lutram_readback_checker.sv
// Walks a single-port LUTRAM: check INIT, write complement, check complement, restore INIT.
// Holds the run FSM, expected-bit selection, mismatch counter and first-error latch.
module lutram_readback_checker
  import lutram_chk_pkg::*;
#(
  parameter int                  ADDR_W = 6,
  parameter logic [2**ADDR_W-1:0] INIT   = '0,
  parameter int                  SETTLE = 2,
  parameter int                  ERR_W  = ADDR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_d_o,
  output logic              ram_we_o,
  input  logic              ram_q_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ERR_W-1:0]  err_count_o,
  output logic              first_err_valid_o,
  output logic [ADDR_W-1:0] first_err_addr_o
);

  state_e            state;
  logic              run;
  logic              write_mode;
  logic              clear;
  logic              sample;
  logic              last_step;
  logic              phase_last;
  logic [ADDR_W-1:0] addr_next;
  logic              expected;
  logic              mismatch;

  assign run        = state inside {SCAN, WRITE, VERIFY, RESTORE};
  assign write_mode = state inside {WRITE, RESTORE};
  assign clear      = (state == IDLE) && start_i;
  assign expected   = INIT[ram_addr_o] ^ (state == VERIFY);
  assign mismatch   = sample && (ram_q_i != expected);

  lutram_chk_walker #(
    .ADDR_W (ADDR_W),
    .SETTLE (SETTLE)
  ) u_walker (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .clear      (clear),
    .run        (run),
    .write_mode (write_mode),
    .addr       (ram_addr_o),
    .addr_next  (addr_next),
    .sample     (sample),
    .last_step  (last_step),
    .phase_last (phase_last),
    .we         (ram_we_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state             <= IDLE;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      pass_o            <= 1'b0;
      err_count_o       <= '0;
      first_err_valid_o <= 1'b0;
      first_err_addr_o  <= '0;
      ram_d_o           <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (mismatch) begin
        if (err_count_o != '1) err_count_o <= err_count_o + ERR_W'(1);
        if (!first_err_valid_o) begin
          first_err_valid_o <= 1'b1;
          first_err_addr_o  <= ram_addr_o;
        end
      end
      // Write data is loaded alongside the address so it is stable from SETUP through HOLD.
      case (state)
        IDLE: begin
          if (start_i) begin
            err_count_o       <= '0;
            first_err_valid_o <= 1'b0;
            first_err_addr_o  <= '0;
            pass_o            <= 1'b0;
            busy_o            <= 1'b1;
            state             <= SCAN;
          end
        end
        SCAN: begin
          if (phase_last) begin
            state   <= WRITE;
            ram_d_o <= ~INIT[0];
          end
        end
        WRITE: begin
          if (phase_last)     state   <= VERIFY;
          else if (last_step) ram_d_o <= ~INIT[addr_next];
        end
        VERIFY: begin
          if (phase_last) begin
            state   <= RESTORE;
            ram_d_o <= INIT[0];
          end
        end
        RESTORE: begin
          if (phase_last) begin
            state  <= DONE;
            done_o <= 1'b1;
            pass_o <= (err_count_o == '0);
          end else if (last_step) begin
            ram_d_o <= INIT[addr_next];
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lutram_readback_checker.sv
// Directed bench: D x 1 RAM model (rising/falling write edge, stuck bits, inverted read)
// driven by the checker; expected results are hand-computed per run.
module tb_lutram_readback_checker;

  localparam int          ADDR_W = 5;
  localparam logic [31:0] INIT   = 32'h0123_4567;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_d;
  logic              ram_we;
  logic              ram_q;
  logic              busy;
  logic              done;
  logic              pass;
  logic [5:0]        err_count;
  logic              first_err_valid;
  logic [ADDR_W-1:0] first_err_addr;

  logic [31:0] mem;
  logic [31:0] load_img = '0;
  logic [31:0] stuck_mask = '0;
  logic        load = 1'b0;
  logic        edge_inv = 1'b0;
  logic        inv_read = 1'b0;
  int          wcount;

  int n_checks = 0;
  int n_fail = 0;
  int cyc;

  lutram_readback_checker #(
    .ADDR_W (ADDR_W),
    .INIT   (INIT),
    .SETTLE (2)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .start_i           (start),
    .ram_addr_o        (ram_addr),
    .ram_d_o           (ram_d),
    .ram_we_o          (ram_we),
    .ram_q_i           (ram_q),
    .busy_o            (busy),
    .done_o            (done),
    .pass_o            (pass),
    .err_count_o       (err_count),
    .first_err_valid_o (first_err_valid),
    .first_err_addr_o  (first_err_addr)
  );

  always #5 clk = ~clk;

  // RAM model: write captured on the rising edge, or the falling edge when edge_inv=1.
  always @(posedge clk or negedge clk) begin
    if (load) begin
      mem    <= load_img;
      wcount <= 0;
    end else if (ram_we && (clk != edge_inv)) begin
      mem[ram_addr] <= ram_d;
      wcount        <= wcount + 1;
    end
  end

  assign ram_q = inv_read ^ (mem[ram_addr] | stuck_mask[ram_addr]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_ram(input logic [31:0] img);
    load_img = img;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // Start a run, optionally poke start mid-run, and measure edges until done_o.
  task automatic run_once(input string name, input bit poke_start, output int cycles);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1;
    check({name, ".busy_on"}, 32'(busy), 32'd1);
    while (!done && cycles < 2000) begin
      if (poke_start) start = (cycles == 50);
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    check({name, ".cycles"}, cycles, 32'd385);
    check({name, ".busy_in_done"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    check({name, ".busy_off"}, 32'(busy), 32'd0);
    check({name, ".done_pulse"}, 32'(done), 32'd0);
    $display("run %s: cycles=%0d pass=%0b err=%0d first=%0d valid=%0b writes=%0d ram=%08h",
             name, cycles, pass, err_count, first_err_addr, first_err_valid, wcount, mem);
  endtask

  task automatic check_result(input string name, input logic exp_pass, input int exp_err,
                              input logic exp_fv, input int exp_fa);
    check({name, ".pass"}, 32'(pass), 32'(exp_pass));
    check({name, ".err_count"}, 32'(err_count), exp_err);
    check({name, ".first_valid"}, 32'(first_err_valid), 32'(exp_fv));
    if (exp_fv) check({name, ".first_addr"}, 32'(first_err_addr), exp_fa);
    check({name, ".ram_image"}, mem, INIT);
    check({name, ".writes"}, wcount, 32'd64);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.pass", 32'(pass), 32'd0);
    check("reset.err_count", 32'(err_count), 32'd0);
    check("reset.first_valid", 32'(first_err_valid), 32'd0);
    check("reset.first_addr", 32'(first_err_addr), 32'd0);
    check("reset.we", 32'(ram_we), 32'd0);
    check("reset.addr", 32'(ram_addr), 32'd0);
    check("reset.d", 32'(ram_d), 32'd0);
    rst_n = 1'b1;

    // Good RAM, rising-edge writes; a stray start mid-run must be ignored.
    load_ram(INIT);
    run_once("good_rise", 1'b1, cyc);
    check_result("good_rise", 1'b1, 0, 1'b0, 0);

    // Good RAM, falling-edge writes.
    edge_inv = 1'b1;
    load_ram(INIT);
    run_once("good_fall", 1'b0, cyc);
    check_result("good_fall", 1'b1, 0, 1'b0, 0);
    edge_inv = 1'b0;

    // Power-up bit 7 wrong: INIT[7]=0, RAM holds 1 -> one SCAN miss.
    load_ram(INIT ^ 32'h0000_0080);
    run_once("bit7_flip", 1'b0, cyc);
    check_result("bit7_flip", 1'b0, 1, 1'b1, 7);

    // Bit 2 stuck-at-1 with INIT[2]=1: SCAN clean, VERIFY expects 0.
    load_ram(INIT);
    stuck_mask = 32'h0000_0004;
    run_once("stuck_b2", 1'b0, cyc);
    check_result("stuck_b2", 1'b0, 1, 1'b1, 2);
    stuck_mask = '0;

    // Inverted read path: all 64 samples miss, counter saturates at 63.
    inv_read = 1'b1;
    load_ram(INIT);
    run_once("inv_read", 1'b0, cyc);
    check_result("inv_read", 1'b0, 63, 1'b1, 0);
    inv_read = 1'b0;

    // Abort with reset while strobing address 10 in WRITE.
    load_ram(INIT);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(ram_we && ram_addr == 5'd10) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort.reached_strobe", 32'(ram_we && ram_addr == 5'd10), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort.we", 32'(ram_we), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.addr", 32'(ram_addr), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort.no_done", 32'(done), 32'd0);
    check("abort.ram_image", mem, INIT ^ 32'h0000_03FF);
    check("abort.writes", wcount, 32'd10);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_once("after_abort", 1'b0, cyc);
    check("after_abort.pass", 32'(pass), 32'd0);
    check("after_abort.err_count", 32'(err_count), 32'd10);
    check("after_abort.first_addr", 32'(first_err_addr), 32'd0);
    check("after_abort.ram_image", mem, INIT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
